// File: rtl/mul_share_arbiter_pkg.sv
// Shared types and constants for the two-requester multiplier-sharing arbiter.
package mul_share_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    DONE  = 2'b10,
    CLEAR = 2'b11
  } arb_state_e;

  localparam int DEFAULT_WIDTH = 64;

  localparam logic REQ0_ID = 1'b0;
  localparam logic REQ1_ID = 1'b1;

endpackage

// File: rtl/mul_share_arbiter_if.sv
// Bundle of requester and multiplier signals around the arbiter.
// The master modport is the arbiter's view; slave is the surrounding system.
interface mul_share_arbiter_if
  import mul_share_arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic               req0;
  logic               req1;
  logic [WIDTH-1:0]   m0_multiplier;
  logic [WIDTH-1:0]   m0_multiplicand;
  logic [WIDTH-1:0]   m1_multiplier;
  logic [WIDTH-1:0]   m1_multiplicand;
  logic               gnt0;
  logic               gnt1;
  logic               done0;
  logic               done1;
  logic [2*WIDTH-1:0] result;
  logic [WIDTH-1:0]   mul_multiplier;
  logic [WIDTH-1:0]   mul_multiplicand;
  logic               mul_op_start;
  logic               mul_op_clear;
  logic               mul_op_done;
  logic [2*WIDTH-1:0] mul_result;
  logic               err;

  modport master (
    input  req0, req1, m0_multiplier, m0_multiplicand, m1_multiplier, m1_multiplicand,
    input  mul_op_done, mul_result,
    output gnt0, gnt1, done0, done1, result,
    output mul_multiplier, mul_multiplicand, mul_op_start, mul_op_clear, err
  );

  modport slave (
    output req0, req1, m0_multiplier, m0_multiplicand, m1_multiplier, m1_multiplicand,
    output mul_op_done, mul_result,
    input  gnt0, gnt1, done0, done1, result,
    input  mul_multiplier, mul_multiplicand, mul_op_start, mul_op_clear, err
  );

endinterface

// File: rtl/mul_share_arbiter_arb_watchdog.sv
// RUN-phase timeout counter: zeroed by clear, counts while enabled,
// flags expire in the LIMIT-th enabled cycle.
module arb_watchdog #(
  parameter int LIMIT = 256
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count_q, count_d;

  assign expire = enable && (count_q == CW'(LIMIT - 1));

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expire) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one multi-cycle multiplier between two requesters.
// Define ARB_TIMEOUT_EN to add a RUN-state watchdog that aborts with an err pulse.
module mul_share_arbiter
  import mul_share_arbiter_pkg::*;
#(
  parameter int WIDTH          = DEFAULT_WIDTH,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                clk,
  input  logic                reset_n,
  mul_share_arbiter_if.master bus
);
  arb_state_e         state_q, state_d;
  logic               last_grant_q, last_grant_d;
  logic               grant_id_q, grant_id_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               err_q, err_d;
  logic               timeout_hit;
  logic               granted_req;
  logic               active;

`ifdef ARB_TIMEOUT_EN
  arb_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state_q != RUN),
    .enable  (state_q == RUN),
    .expire  (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
  end
`endif

  assign granted_req = (grant_id_q == REQ1_ID) ? bus.req1 : bus.req0;

  // A dropped request beats a same-cycle mul_op_done so an abandoned operation never reports done.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    result_d     = result_q;
    err_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req0 && bus.req1) begin
          grant_id_d = ~last_grant_q;
          state_d    = RUN;
        end else if (bus.req0) begin
          grant_id_d = REQ0_ID;
          state_d    = RUN;
        end else if (bus.req1) begin
          grant_id_d = REQ1_ID;
          state_d    = RUN;
        end
      end
      RUN: begin
        if (!granted_req) begin
          state_d = CLEAR;
        end else if (bus.mul_op_done) begin
          result_d = bus.mul_result;
          state_d  = DONE;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = CLEAR;
        end
      end
      DONE: begin
        if (!granted_req) begin
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        last_grant_d = grant_id_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= REQ1_ID;
      grant_id_q   <= REQ0_ID;
      result_q     <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      result_q     <= result_d;
      err_q        <= err_d;
    end
  end

  assign active = (state_q == RUN) || (state_q == DONE);

  assign bus.gnt0         = active && (grant_id_q == REQ0_ID);
  assign bus.gnt1         = active && (grant_id_q == REQ1_ID);
  assign bus.done0        = (state_q == DONE) && (grant_id_q == REQ0_ID);
  assign bus.done1        = (state_q == DONE) && (grant_id_q == REQ1_ID);
  assign bus.result       = result_q;
  assign bus.mul_op_start = (state_q == RUN);
  assign bus.mul_op_clear = (state_q == CLEAR);
  assign bus.err          = err_q;

  assign bus.mul_multiplier   = bus.gnt0 ? bus.m0_multiplier :
                                bus.gnt1 ? bus.m1_multiplier : '0;
  assign bus.mul_multiplicand = bus.gnt0 ? bus.m0_multiplicand :
                                bus.gnt1 ? bus.m1_multiplicand : '0;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed self-checking bench for mul_share_arbiter with a 4-cycle multiplier model.
module tb_mul_share_arbiter;
  localparam int W  = 64;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  mul_share_arbiter_if #(.WIDTH(W)) bus ();

  mul_share_arbiter #(
    .WIDTH          (W),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Multiplier model: done asserts after four RUN cycles and holds until clear.
  logic [2:0]     m_cnt;
  logic           m_done;
  logic [2*W-1:0] m_res;
  logic           m_hang = 1'b0;
  logic           force_done = 1'b0;
  logic [2*W-1:0] force_res = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_cnt  <= '0;
      m_done <= 1'b0;
      m_res  <= '0;
    end else if (bus.mul_op_clear) begin
      m_cnt  <= '0;
      m_done <= 1'b0;
    end else if (bus.mul_op_start && !m_done && !m_hang) begin
      if (m_cnt == 3'd3) begin
        m_done <= 1'b1;
        m_res  <= {64'b0, bus.mul_multiplier} * {64'b0, bus.mul_multiplicand};
      end else begin
        m_cnt <= m_cnt + 3'd1;
      end
    end
  end

  assign bus.mul_op_done = m_done | force_done;
  assign bus.mul_result  = force_done ? force_res : m_res;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_mul_done(input string tag);
    int n = 0;
    while (bus.mul_op_done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (bus.mul_op_done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s_wait: mul_op_done got %0b expected 1 within 20 cycles", tag, bus.mul_op_done);
    end
  endtask

  task automatic apply_reset();
    reset_n  = 1'b0;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.m0_multiplier = '0; bus.m0_multiplicand = '0;
    bus.m1_multiplier = '0; bus.m1_multiplicand = '0;
    #2;
    checks++;
    if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.mul_op_start, bus.mul_op_clear, bus.err} !== 7'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b expected 0000000",
               {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.mul_op_start, bus.mul_op_clear, bus.err});
    end
    checks++;
    if (bus.result !== '0 || bus.mul_multiplier !== '0) begin
      errors++;
      $display("[TB] FAIL reset_data: result %0h mul_multiplier %0h expected 0 0", bus.result, bus.mul_multiplier);
    end
    apply_reset();
  endtask

  task automatic test_single();
    bus.m0_multiplier = 64'd7; bus.m0_multiplicand = 64'd9;
    bus.req0 = 1'b1;
    tick();
    checks++;
    if ({bus.gnt0, bus.gnt1, bus.mul_op_start} !== 3'b101) begin
      errors++;
      $display("[TB] FAIL single_grant: gnt0/gnt1/start got %b expected 101", {bus.gnt0, bus.gnt1, bus.mul_op_start});
    end
    checks++;
    if (bus.mul_multiplier !== 64'd7 || bus.mul_multiplicand !== 64'd9) begin
      errors++;
      $display("[TB] FAIL single_operands: got %0d,%0d expected 7,9", bus.mul_multiplier, bus.mul_multiplicand);
    end
    wait_mul_done("single");
    checks++;
    if (bus.done0 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_done_latency: done0 got %0b expected 0 in mul_op_done cycle", bus.done0);
    end
    tick();
    checks++;
    if (bus.done0 !== 1'b1 || bus.result !== 128'd63 || bus.mul_op_start !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_done: done0 %0b result %0d start %0b expected 1 63 0", bus.done0, bus.result, bus.mul_op_start);
    end
    bus.req0 = 1'b0;
    tick();
    checks++;
    if (bus.mul_op_clear !== 1'b1 || bus.gnt0 !== 1'b0 || bus.done0 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_clear: clear %0b gnt0 %0b done0 %0b expected 1 0 0", bus.mul_op_clear, bus.gnt0, bus.done0);
    end
    tick();
    checks++;
    if (bus.mul_op_clear !== 1'b0 || bus.gnt0 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_idle: clear %0b gnt0 %0b expected 0 0", bus.mul_op_clear, bus.gnt0);
    end
  endtask

  task automatic test_contention();
    apply_reset();
    bus.m0_multiplier = 64'd3; bus.m0_multiplicand = 64'd5;
    bus.m1_multiplier = 64'd6; bus.m1_multiplicand = 64'd11;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    tick();
    checks++;
    if ({bus.gnt0, bus.gnt1} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL contend_first: gnt0/gnt1 got %b expected 10", {bus.gnt0, bus.gnt1});
    end
    wait_mul_done("contend0");
    tick();
    checks++;
    if (bus.done0 !== 1'b1 || bus.result !== 128'd15 || bus.gnt1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL contend_done0: done0 %0b result %0d gnt1 %0b expected 1 15 0", bus.done0, bus.result, bus.gnt1);
    end
    bus.req0 = 1'b0;
    tick();
    checks++;
    if ({bus.gnt0, bus.gnt1} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL contend_clear_nogrant: gnt0/gnt1 got %b expected 00", {bus.gnt0, bus.gnt1});
    end
    tick();
    tick();
    checks++;
    if ({bus.gnt0, bus.gnt1} !== 2'b01 || bus.mul_multiplier !== 64'd6) begin
      errors++;
      $display("[TB] FAIL contend_second: gnt %b mul_multiplier %0d expected 01 6", {bus.gnt0, bus.gnt1}, bus.mul_multiplier);
    end
    wait_mul_done("contend1");
    tick();
    checks++;
    if (bus.done1 !== 1'b1 || bus.result !== 128'd66 || bus.gnt0 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL contend_done1: done1 %0b result %0d gnt0 %0b expected 1 66 0", bus.done1, bus.result, bus.gnt0);
    end
    bus.req1 = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    logic exp_id;
    bus.m0_multiplier = 64'd2; bus.m0_multiplicand = 64'd3;
    bus.m1_multiplier = 64'd4; bus.m1_multiplicand = 64'd5;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      exp_id = k[0];
      checks++;
      if ({bus.gnt0, bus.gnt1} !== (exp_id ? 2'b01 : 2'b10)) begin
        errors++;
        $display("[TB] FAIL b2b_grant_%0d: gnt0/gnt1 got %b expected %b", k, {bus.gnt0, bus.gnt1}, exp_id ? 2'b01 : 2'b10);
      end
      wait_mul_done("b2b");
      tick();
      checks++;
      if ((exp_id ? bus.done1 : bus.done0) !== 1'b1 || bus.result !== (exp_id ? 128'd20 : 128'd6)) begin
        errors++;
        $display("[TB] FAIL b2b_done_%0d: done %0b result %0d expected 1 %0d", k,
                 exp_id ? bus.done1 : bus.done0, bus.result, exp_id ? 20 : 6);
      end
      if (k == 3) begin
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
      end else if (exp_id) begin
        bus.req1 = 1'b0;
      end else begin
        bus.req0 = 1'b0;
      end
      tick();
      checks++;
      if (bus.mul_op_clear !== 1'b1 || {bus.gnt0, bus.gnt1} !== 2'b00) begin
        errors++;
        $display("[TB] FAIL b2b_clear_%0d: clear %0b gnt %b expected 1 00", k, bus.mul_op_clear, {bus.gnt0, bus.gnt1});
      end
      bus.req0 = (k < 3);
      bus.req1 = (k < 3);
      tick();
      checks++;
      if ({bus.gnt0, bus.gnt1, bus.mul_op_clear} !== 3'b000) begin
        errors++;
        $display("[TB] FAIL b2b_gap_%0d: gnt/clear got %b expected 000", k, {bus.gnt0, bus.gnt1, bus.mul_op_clear});
      end
      if (k < 3) tick();
    end
  endtask

  task automatic test_abort();
    bus.m1_multiplier = 64'd8; bus.m1_multiplicand = 64'd8;
    bus.req1 = 1'b1;
    tick();
    checks++;
    if (bus.gnt1 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort_grant: gnt1 got %0b expected 1", bus.gnt1);
    end
    tick();
    bus.req1 = 1'b0;
    tick();
    checks++;
    if (bus.mul_op_clear !== 1'b1 || bus.done1 !== 1'b0 || bus.result !== 128'd20) begin
      errors++;
      $display("[TB] FAIL abort_clear: clear %0b done1 %0b result %0d expected 1 0 20", bus.mul_op_clear, bus.done1, bus.result);
    end
    tick();
    bus.m0_multiplier = 64'd2; bus.m0_multiplicand = 64'd3;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    tick();
    checks++;
    if ({bus.gnt0, bus.gnt1} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL abort_next_grant: gnt0/gnt1 got %b expected 10", {bus.gnt0, bus.gnt1});
    end
    bus.req1 = 1'b0;
    wait_mul_done("abort_next");
    tick();
    bus.req0 = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_done_abort_same_cycle();
    bus.m0_multiplier = 64'd7; bus.m0_multiplicand = 64'd7;
    bus.req0 = 1'b1;
    tick();
    wait_mul_done("race");
    bus.req0 = 1'b0;
    tick();
    checks++;
    if (bus.mul_op_clear !== 1'b1 || bus.done0 !== 1'b0 || bus.result !== 128'd6) begin
      errors++;
      $display("[TB] FAIL race_abort: clear %0b done0 %0b result %0d expected 1 0 6", bus.mul_op_clear, bus.done0, bus.result);
    end
    tick();
  endtask

  task automatic test_done_outside_run();
    force_res  = 128'hDEAD;
    force_done = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1} !== 4'b0000 || bus.result !== 128'd6) begin
      errors++;
      $display("[TB] FAIL stray_done: gnt/done %b result %0h expected 0000 6",
               {bus.gnt0, bus.gnt1, bus.done0, bus.done1}, bus.result);
    end
    force_done = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_op();
    bus.m1_multiplier = 64'd10; bus.m1_multiplicand = 64'd12;
    bus.req1 = 1'b1;
    tick();
    checks++;
    if (bus.gnt1 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rst_pre_grant: gnt1 got %0b expected 1", bus.gnt1);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.gnt1, bus.mul_op_start, bus.done1} !== 3'b000 || bus.mul_multiplier !== '0 || bus.result !== '0) begin
      errors++;
      $display("[TB] FAIL rst_async: gnt1/start/done1 %b mul_multiplier %0d result %0d expected 000 0 0",
               {bus.gnt1, bus.mul_op_start, bus.done1}, bus.mul_multiplier, bus.result);
    end
    #3 reset_n = 1'b1;
    tick();
    checks++;
    if ({bus.gnt0, bus.gnt1} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL rst_regrant: gnt0/gnt1 got %b expected 01", {bus.gnt0, bus.gnt1});
    end
    wait_mul_done("rst");
    tick();
    checks++;
    if (bus.done1 !== 1'b1 || bus.result !== 128'd120) begin
      errors++;
      $display("[TB] FAIL rst_done: done1 %0b result %0d expected 1 120", bus.done1, bus.result);
    end
    bus.req1 = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_timeout();
    logic seen_err;
    m_hang = 1'b1;
    seen_err = 1'b0;
    bus.m0_multiplier = 64'd1; bus.m0_multiplicand = 64'd1;
    bus.req0 = 1'b1;
    tick();
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < TO - 1; i++) begin
      if (bus.err !== 1'b0) seen_err = 1'b1;
      tick();
    end
    if (bus.err !== 1'b0) seen_err = 1'b1;
    checks++;
    if (seen_err !== 1'b0 || bus.gnt0 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL timeout_early: err seen %0b gnt0 %0b expected 0 1", seen_err, bus.gnt0);
    end
    tick();
    checks++;
    if (bus.err !== 1'b1 || bus.mul_op_clear !== 1'b1 || bus.done0 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_fire: err %0b clear %0b done0 %0b expected 1 1 0", bus.err, bus.mul_op_clear, bus.done0);
    end
    bus.req0 = 1'b0;
    tick();
    checks++;
    if (bus.err !== 1'b0 || bus.gnt0 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_pulse: err %0b gnt0 %0b expected 0 0", bus.err, bus.gnt0);
    end
`else
    for (int i = 0; i < 20; i++) begin
      if (bus.err !== 1'b0) seen_err = 1'b1;
      tick();
    end
    checks++;
    if (seen_err !== 1'b0 || bus.gnt0 !== 1'b1 || bus.mul_op_start !== 1'b1 || bus.err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL no_timeout: err seen %0b gnt0 %0b start %0b expected 0 1 1", seen_err, bus.gnt0, bus.mul_op_start);
    end
    bus.req0 = 1'b0;
    tick();
    tick();
`endif
    m_hang = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_abort();
    test_done_abort_same_cycle();
    test_done_outside_run();
    test_reset_mid_op();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation time %0t exceeded limit", $time);
    $fatal(1, "[TB] stopping");
  end

endmodule
